key_expansion: RTL and testbench
================================

Name: key_expansion

Overview:
- Iterative AES-128 key schedule generator. It produces round keys 0..10 one at a time from a 128-bit cipher key.
- Feeds the AddRoundKey stage that sits directly upstream of SubBytes in the round datapath. The round controller consumes round keys through a valid/ready handshake.
- One round key is computed per accepted handshake. The block holds no key storage beyond the current round key.

Parameters:
- NR, 10, number of rounds after the initial key; fixed for AES-128; sets the final round_idx value.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- key_in  input  128  cipher key; byte 0 at [127:120]; word w0 at [127:96].
- key_valid  input  1  key_in is valid.
- key_ready  output  1  block is idle and will accept a key.
- rk_out  output  128  current round key, same byte ordering as key_in.
- rk_idx  output  4  round number of rk_out, 0..10.
- rk_valid  output  1  rk_out and rk_idx are valid.
- rk_ready  input  1  consumer accepts rk_out this cycle.
- rk_last  output  1  high with rk_valid when rk_idx==10.

Behaviour:
- Reset (rst_n==0 at a clk edge): state goes to IDLE; rk_out=0, rk_idx=0, rk_valid=0, rk_last=0. key_ready=1 from the first cycle after reset.
- Reset mid-operation abandons the current schedule. No further round keys are emitted; the consumer sees rk_valid drop the cycle after reset is sampled.
- FSM states: IDLE and EMIT.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&&key_ready at edge T: rk_out<=key_in, rk_idx<=0, next state EMIT.
  - Round key 0 is visible with rk_valid=1 in cycle T+1.
- EMIT:
  - key_ready=0; key_valid is ignored and key_in is not sampled.
  - rk_valid=1 continuously; rk_out and rk_idx stay stable until the handshake.
  - On rk_valid&&rk_ready with rk_idx<10: rk_out<=next_key(rk_out, rk_idx+1), rk_idx<=rk_idx+1; remain in EMIT.
  - On rk_valid&&rk_ready with rk_idx==10: next state IDLE, rk_valid<=0. rk_out and rk_idx hold their last values.
- rk_last = rk_valid && (rk_idx==10).
- Throughput: with rk_ready tied high, keys 0..10 appear in cycles T+1..T+11, and key_ready is high again in T+12. Minimum spacing between accepted keys is 12 cycles.
- next_key(w0..w3, r):
  - t = SubWord(RotWord(w3)) ^ {RCON[r], 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- RotWord({a,b,c,d}) = {b,c,d,a}.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36. Index 0 is never used.
- All arithmetic is GF(2) XOR; there are no carries. rk_idx never exceeds 10 and never wraps.
- The next-key datapath is combinational from registered rk_out. It uses four sbox lookups in a single cycle, with no extra pipeline stage.

Decomposition:
- Shared include aes_defs.vh holds:
  - RCON constant table/function;
  - AES_NR=10;
  - word and byte slice macros for the 128-bit state ordering, common with SubBytes.
- Sub-module sub_word: 32-bit in and 32-bit out, built from four instances of the existing sbox. It is instantiated once, on RotWord(w3).

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> rk_idx 0 gives the key itself; rk_idx 1 = a0fafe1788542cb123a339392a6c7605; rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1; 11 consecutive valid cycles; key_ready=1 the cycle after.
- All-zero key -> rk_idx 1 = 62636363626363636263636362636363; rk_idx 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: rk_ready=0 for 3 cycles while rk_idx==4 -> rk_out/rk_idx unchanged and rk_valid held; the sequence resumes with correct round 5.
- key_valid pulsed with a different key during EMIT -> ignored; the schedule output matches the original key; key_ready stays 0 until after round 10 is accepted.
- rst_n=0 for one cycle while rk_idx==5 -> next cycle rk_valid=0, rk_idx=0, rk_out=0, key_ready=1; a new key then produces a correct full schedule.
- Two keys offered back-to-back with key_valid held high -> second accepted exactly in the cycle key_ready returns; its round 0 appears 12 cycles after the first key's round 0.

Source files
------------

// File: rtl/key_expansion_pkg.sv
// Shared AES-128 definitions for the key schedule: round count, round
// constants, the forward S-box and word slicing of the 128-bit state.
package key_expansion_pkg;

  localparam int AES_NR = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ke_state_t;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  // Round constant for round r (1..10); r==0 never occurs in the schedule.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Word i of the state; word 0 occupies the most significant bits.
  function automatic logic [31:0] get_word(input logic [127:0] st, input int i);
    return st[127-32*i -: 32];
  endfunction

endpackage

// File: rtl/key_expansion_sub_word.sv
// SubWord: the AES S-box applied independently to each byte of a word.
module key_expansion_sub_word
  import key_expansion_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] s
);

  // One S-box lookup per byte lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign s[8*gi +: 8] = sbox(w[8*gi +: 8]);
  end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..NR one per accepted
// valid/ready handshake, holding only the current round key.
module key_expansion
  import key_expansion_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ke_state_t    state_reg, state_next;
  logic [127:0] rk_reg, rk_next;
  logic [3:0]   idx_reg, idx_next;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_rot, t_word;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [3:0]   idx_inc;
  logic [127:0] rk_step;

  assign w0 = get_word(rk_reg, 0);
  assign w1 = get_word(rk_reg, 1);
  assign w2 = get_word(rk_reg, 2);
  assign w3 = get_word(rk_reg, 3);

  assign rot_w3  = {w3[23:0], w3[31:24]};
  assign idx_inc = idx_reg + 4'd1;

  key_expansion_sub_word u_sub_word (
    .w (rot_w3),
    .s (sub_rot)
  );

  // Next round key, combinational from the registered current key.
  always_comb begin
    t_word  = sub_rot ^ {rcon(idx_inc), 24'h0};
    nw0     = w0 ^ t_word;
    nw1     = w1 ^ nw0;
    nw2     = w2 ^ nw1;
    nw3     = w3 ^ nw2;
    rk_step = {nw0, nw1, nw2, nw3};
  end

  // Next-state logic: load a key in IDLE, advance one round per handshake in EMIT.
  always_comb begin
    state_next = state_reg;
    rk_next    = rk_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (key_valid) begin
          rk_next    = key_in;
          idx_next   = 4'd0;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_reg == LAST_IDX) begin
            // Final key consumed: keep its value and index, go idle.
            state_next = ST_IDLE;
          end else begin
            rk_next  = rk_step;
            idx_next = idx_inc;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and round-key registers; reset abandons any schedule in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rk_reg    <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rk_reg    <= rk_next;
      idx_reg   <= idx_next;
    end
  end

  assign key_ready = (state_reg == ST_IDLE);
  assign rk_valid  = (state_reg == ST_EMIT);
  assign rk_out    = rk_reg;
  assign rk_idx    = idx_reg;
  assign rk_last   = rk_valid && (idx_reg == LAST_IDX);

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion with a scoreboard of known round keys.
module tb_key_expansion;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;

  key_expansion dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_last   (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS-197 A.1 schedule and the all-zero-key schedule.
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_schedule(input bit use_fips);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx = 4'(i);
      e.key = use_fips ? FIPS_RK[i] : ZERO_RK[i];
      exp_q.push_back(e);
    end
  endtask

  // Compare the round key presented this cycle with the scoreboard head.
  task automatic compare_front(input string tag);
    exp_t e;
    check({tag, "_valid"}, 128'(rk_valid), 128'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 128'(exp_q.size()), 128'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_rk%0d", tag, e.idx), rk_out, e.key);
      check($sformatf("%s_idx%0d", tag, e.idx), 128'(rk_idx), 128'(e.idx));
      check($sformatf("%s_last%0d", tag, e.idx), 128'(rk_last), 128'(e.idx == 4'd10));
      $display("tb: %s round %0d key %h", tag, e.idx, rk_out);
    end
  endtask

  // Consume round keys with rk_ready high until the scoreboard drains.
  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    rk_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      if (rk_valid) compare_front(tag);
      tick();
      n++;
    end
    check({tag, "_drain_left"}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic offer_key(input logic [127:0] k);
    check("offer_key_ready", 128'(key_ready), 128'd1);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    int first_t;
    int second_t;
    int accepts;
    int n;

    rst_n     = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_rk_valid", 128'(rk_valid), 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    check("rst_rk_out", rk_out, 128'd0);
    check("rst_rk_last", 128'(rk_last), 128'd0);

    // FIPS-197 key, rk_ready high: 11 consecutive valid cycles.
    rk_ready = 1'b1;
    push_schedule(1'b1);
    offer_key(FIPS_RK[0]);
    for (int i = 0; i < 11; i++) begin
      check("fips_busy", 128'(key_ready), 128'd0);
      compare_front("fips");
      tick();
    end
    check("fips_end_valid", 128'(rk_valid), 128'd0);
    check("fips_end_key_ready", 128'(key_ready), 128'd1);
    check("fips_hold_rk", rk_out, FIPS_RK[10]);
    check("fips_hold_idx", 128'(rk_idx), 128'd10);

    // All-zero key.
    push_schedule(1'b0);
    offer_key(128'd0);
    drain("zero", 20);

    // Backpressure at round 4.
    push_schedule(1'b1);
    offer_key(FIPS_RK[0]);
    for (int i = 0; i < 4; i++) begin
      compare_front("bp");
      tick();
    end
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 128'(rk_valid), 128'd1);
      check("bp_hold_idx", 128'(rk_idx), 128'd4);
      check("bp_hold_rk", rk_out, FIPS_RK[4]);
    end
    drain("bp", 20);

    // key_valid pulsed with another key during EMIT is ignored.
    push_schedule(1'b1);
    offer_key(FIPS_RK[0]);
    for (int i = 0; i < 2; i++) begin
      compare_front("ign");
      tick();
    end
    key_in    = 128'hffeeddccbbaa99887766554433221100;
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ign_key_ready", 128'(key_ready), 128'd0);
      compare_front("ign");
      tick();
    end
    key_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      check("ign_key_ready", 128'(key_ready), 128'd0);
      compare_front("ign");
      tick();
      n++;
    end
    check("ign_drain_left", 128'(exp_q.size()), 128'd0);
    check("ign_end_key_ready", 128'(key_ready), 128'd1);

    // Reset while round 5 is presented.
    push_schedule(1'b0);
    offer_key(128'd0);
    for (int i = 0; i < 5; i++) begin
      compare_front("rst");
      tick();
    end
    check("rst_mid_idx", 128'(rk_idx), 128'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("rstmid_rk_valid", 128'(rk_valid), 128'd0);
    check("rstmid_rk_idx", 128'(rk_idx), 128'd0);
    check("rstmid_rk_out", rk_out, 128'd0);
    check("rstmid_key_ready", 128'(key_ready), 128'd1);
    push_schedule(1'b1);
    offer_key(FIPS_RK[0]);
    drain("after_rst", 20);

    // Two keys offered back-to-back with key_valid held high.
    push_schedule(1'b0);
    push_schedule(1'b1);
    rk_ready  = 1'b1;
    key_in    = 128'd0;
    key_valid = 1'b1;
    first_t   = -1;
    second_t  = -1;
    accepts   = 0;
    n         = 0;
    while (exp_q.size() > 0 && n < 60) begin
      if (key_ready && key_valid) accepts++;
      if (rk_valid && rk_idx == 4'd0) begin
        if (first_t < 0) first_t = cyc;
        else second_t = cyc;
      end
      if (rk_valid) compare_front("b2b");
      tick();
      n++;
      if (accepts == 1) key_in = FIPS_RK[0];
      if (accepts >= 2) key_valid = 1'b0;
    end
    key_valid = 1'b0;
    check("b2b_drain_left", 128'(exp_q.size()), 128'd0);
    check("b2b_accepts", 128'(accepts), 128'd2);
    check("b2b_spacing", 128'(second_t - first_t), 128'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
